multiplier_block_sequencer: RTL and testbench
=============================================

// Module: multiplier_block_sequencer
// PURPOSE
// - Computes an unsigned (NUM_BLOCKS*BLOCK_LENGTH)-bit x (NUM_BLOCKS*BLOCK_LENGTH)-bit product.
// - Reuses a single multiplier_16x16 instance (BLOCK_LENGTH x BLOCK_LENGTH, combinational) every cycle.
// - Schedules one partial product per cycle and shift-accumulates it into a full-width result.
// - Sits between operand producers and the wide-multiply consumers; valid/ready on both sides.
// PARAMETERS
// - NUM_BLOCKS    4                     operand width in BLOCK_LENGTH-bit blocks (>=1)
// - BLOCK_LENGTH  multiplier_pkg value  block width; not overridable here, fixed at 16
// - OP_W          NUM_BLOCKS*BLOCK_LENGTH  derived localparam, operand width
// PORTS
// - clk_i        in   1       rising-edge clock
// - rst_i        in   1       synchronous reset, active high
// - in_valid_i   in   1       operands valid
// - in_ready_o   out  1       sequencer can accept operands (high only in IDLE)
// - op_a_i       in   OP_W    operand a, unsigned
// - op_b_i       in   OP_W    operand b, unsigned
// - out_valid_o  out  1       result valid (held until accepted)
// - out_ready_i  in   1       consumer accepts result
// - result_o     out  2*OP_W  a*b, unsigned
// - busy_o       out  1       high in any state other than IDLE
// BEHAVIOUR
// - Reset: FSM=IDLE, counters i=j=0, accumulator=0, in_ready_o=1, out_valid_o=0, result_o=0, busy_o=0.
// - Reset mid-operation: aborts the operation; the partial result is discarded and nothing is emitted.
// - FSM states: IDLE -> MUL -> [FLUSH] -> DONE -> IDLE.
// - IDLE: when in_valid_i & in_ready_o, register op_a_i/op_b_i, clear acc, set i=j=0, go to MUL.
// - MUL: each cycle a_blk[i]*b_blk[j] feeds the multiplier.
//   - The 2*BLOCK_LENGTH product is zero-extended, shifted left by (i+j)*BLOCK_LENGTH, and added into acc.
//   - j increments; on j=NUM_BLOCKS-1, j wraps to 0 and i increments.
//   - After i=j=NUM_BLOCKS-1 the FSM leaves MUL.
//   - MUL always lasts exactly NUM_BLOCKS^2 cycles.
// - acc width is 2*OP_W; the final sum always fits, so there is no overflow or carry-out.
// - DONE: out_valid_o=1 and result_o=acc, both stable until out_ready_i.
//   - On handshake, go to IDLE; in_ready_o rises the following cycle.
// - Latency (base): accept at cycle T -> out_valid_o first high at T+NUM_BLOCKS^2+1.
// - Throughput: one operation per NUM_BLOCKS^2+2 cycles minimum when out_ready_i is held high.
// - in_valid_i outside IDLE is ignored; operands are captured, so inputs may change after acceptance.
// - result_o holds its last value in IDLE until the next DONE.
// - NUM_BLOCKS=1: MUL lasts 1 cycle; result equals a single multiplier_16x16 output.
// CONFIGURATION
// - Macro MULT_SEQ_PIPE_REG_EN.
// - Defined:
//   - The multiplier output plus its shift index is registered before accumulation.
//   - The accumulate happens one cycle after issue.
//   - An extra FLUSH state (1 cycle) follows MUL to add the last product.
//   - Latency becomes T+NUM_BLOCKS^2+2.
// - Undefined: the multiplier output is accumulated combinationally in the issue cycle, with no FLUSH state.
// - The result value is identical in both builds.
// TESTING
// - NUM_BLOCKS=4, a=3, b=5, out_ready=1 -> result=15.
//   - out_valid at T+17 (T+18 with MULT_SEQ_PIPE_REG_EN).
// - a=b=64'hFFFF_FFFF_FFFF_FFFF -> result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
// - Backpressure: out_ready=0 for 5 cycles in DONE.
//   - result/out_valid stay stable; in_ready stays 0; an in_valid pulse is not captured.
// - rst_i asserted at the 8th MUL cycle of a=b=2^63.
//   - Next cycle: IDLE, in_ready=1, out_valid=0, no result emitted.
//   - A new op a=7, b=9 then yields 63.
// - Back-to-back ops with in_valid held high:
//   - Each op is accepted exactly once per IDLE.
//   - 1000 random operand pairs match a reference a*b.

Source files
------------

// File: rtl/multiplier_block_sequencer_if.sv
// Handshake bundle for multiplier_block_sequencer: operand side (in_*) and result side (out_*).
// The sequencer uses the slave modport; the operand producer / result consumer uses master.
interface multiplier_block_sequencer_if #(
  parameter int OP_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              out_valid;
  logic              out_ready;
  logic [2*OP_W-1:0] result;
  logic              busy;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/multiplier_block_sequencer.sv
// Unsigned OP_W x OP_W multiplier built from NUM_BLOCKS^2 passes through one 16x16 multiplier.
// Optional macro MULT_SEQ_PIPE_REG_EN registers each partial product before it is accumulated.
module multiplier_16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = 32'(a) * 32'(b);
endmodule

module multiplier_block_sequencer #(
  parameter int NUM_BLOCKS = 4
) (
  input logic                         clk_i,
  input logic                         rst_i,
  multiplier_block_sequencer_if.slave bus
);
  localparam int BLOCK_LENGTH = 16;
  localparam int OP_W         = NUM_BLOCKS * BLOCK_LENGTH;
  localparam int ACC_W        = 2 * OP_W;
  localparam int CNT_W        = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int IDX_W        = CNT_W + 1;
  localparam int SH_W         = $clog2(ACC_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [OP_W-1:0]           a_r;
  logic [OP_W-1:0]           b_r;
  logic [CNT_W-1:0]          i_r;
  logic [CNT_W-1:0]          j_r;
  logic [ACC_W-1:0]          acc_r;
  logic [ACC_W-1:0]          acc_nxt_s;
  logic [ACC_W-1:0]          add_term_s;
  logic [ACC_W-1:0]          result_r;
  logic [BLOCK_LENGTH-1:0]   blk_a_s;
  logic [BLOCK_LENGTH-1:0]   blk_b_s;
  logic [2*BLOCK_LENGTH-1:0] product_s;
  logic [2*BLOCK_LENGTH-1:0] add_prod_s;
  logic [IDX_W-1:0]          issue_idx_s;
  logic [IDX_W-1:0]          add_idx_s;
  logic [SH_W-1:0]           shamt_s;
  logic                      add_en_s;
  logic                      accept_s;
  logic                      issue_s;
  logic                      last_s;
  logic                      load_result_s;
  logic                      in_ready_s;
  logic                      out_valid_s;
  logic                      busy_s;

  assign blk_a_s     = a_r[i_r*BLOCK_LENGTH +: BLOCK_LENGTH];
  assign blk_b_s     = b_r[j_r*BLOCK_LENGTH +: BLOCK_LENGTH];
  assign issue_idx_s = IDX_W'(i_r) + IDX_W'(j_r);
  assign last_s      = (i_r == LAST_BLK) && (j_r == LAST_BLK);
  assign accept_s    = in_ready_s & bus.in_valid;

  multiplier_16x16 u_mul (
    .a (blk_a_s),
    .b (blk_b_s),
    .p (product_s)
  );

`ifdef MULT_SEQ_PIPE_REG_EN
  logic [2*BLOCK_LENGTH-1:0] prod_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      pvalid_r;

  // Pipeline register between the multiplier and the accumulator
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_r   <= {(2*BLOCK_LENGTH){1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      pvalid_r <= 1'b0;
    end else begin
      prod_r   <= product_s;
      idx_r    <= issue_idx_s;
      pvalid_r <= issue_s;
    end
  end

  assign add_prod_s = prod_r;
  assign add_idx_s  = idx_r;
  assign add_en_s   = pvalid_r;
`else
  assign add_prod_s = product_s;
  assign add_idx_s  = issue_idx_s;
  assign add_en_s   = issue_s;
`endif

  // Block (i+j) lands at bit offset (i+j)*BLOCK_LENGTH; 2*OP_W bits always hold the full sum
  always_comb begin
    shamt_s    = SH_W'(add_idx_s) * SH_W'(BLOCK_LENGTH);
    add_term_s = ACC_W'(add_prod_s) << shamt_s;
    if (add_en_s) begin
      acc_nxt_s = acc_r + add_term_s;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (last_s) begin
`ifdef MULT_SEQ_PIPE_REG_EN
          state_nxt_s = FLUSH;
`else
          state_nxt_s = DONE;
`endif
        end else begin
          state_nxt_s = MUL;
        end
      end
      FLUSH: state_nxt_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode; the result register loads on the cycle that adds the final product
  always_comb begin
    in_ready_s    = 1'b0;
    out_valid_s   = 1'b0;
    busy_s        = 1'b1;
    issue_s       = 1'b0;
    load_result_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
      MUL: begin
        issue_s = 1'b1;
`ifndef MULT_SEQ_PIPE_REG_EN
        load_result_s = last_s;
`endif
      end
      FLUSH: begin
`ifdef MULT_SEQ_PIPE_REG_EN
        load_result_s = 1'b1;
`endif
      end
      DONE: out_valid_s = 1'b1;
      default: busy_s = 1'b1;
    endcase
  end

  // Operand capture, block counters and accumulator
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_r   <= {OP_W{1'b0}};
      b_r   <= {OP_W{1'b0}};
      i_r   <= {CNT_W{1'b0}};
      j_r   <= {CNT_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
    end else if (accept_s) begin
      a_r   <= bus.op_a;
      b_r   <= bus.op_b;
      i_r   <= {CNT_W{1'b0}};
      j_r   <= {CNT_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
    end else begin
      acc_r <= acc_nxt_s;
      if (issue_s) begin
        if (j_r == LAST_BLK) begin
          j_r <= {CNT_W{1'b0}};
          if (i_r == LAST_BLK) begin
            i_r <= {CNT_W{1'b0}};
          end else begin
            i_r <= i_r + CNT_W'(1);
          end
        end else begin
          j_r <= j_r + CNT_W'(1);
        end
      end
    end
  end

  // Result holding register: stable through DONE and kept while IDLE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_r <= {ACC_W{1'b0}};
    end else if (load_result_s) begin
      result_r <= acc_nxt_s;
    end else begin
      result_r <= result_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.busy      = busy_s;
  assign bus.result    = result_r;
endmodule

// File: tb/tb_multiplier_block_sequencer.sv
// Directed self-checking bench for multiplier_block_sequencer (NUM_BLOCKS=4, 64x64 -> 128).
// Honours MULT_SEQ_PIPE_REG_EN for the expected latency.
module tb_multiplier_block_sequencer;
  localparam int NUM_BLOCKS = 4;
  localparam int OP_W       = 64;
  localparam int NOPS       = 1004;
`ifdef MULT_SEQ_PIPE_REG_EN
  localparam int LAT = NUM_BLOCKS * NUM_BLOCKS + 2;
`else
  localparam int LAT = NUM_BLOCKS * NUM_BLOCKS + 1;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   cyc          = 0;

  logic [63:0] va [NOPS];
  logic [63:0] vb [NOPS];

  multiplier_block_sequencer_if #(.OP_W(OP_W)) bus ();

  multiplier_block_sequencer #(.NUM_BLOCKS(NUM_BLOCKS)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands, waits for acceptance, then scrambles the inputs
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    int k;
    @(negedge clk_i);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    if (!bus.in_ready) check_value("accept_timeout", 128'd0, 128'd1);
    @(posedge clk_i);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
  endtask

  // Returns the cycle count from acceptance to the first out_valid sample
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!bus.out_valid && lat < 200);
    if (!bus.out_valid) check_value("result_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int prev_cyc;
    logic [127:0] exp;

    bus.in_valid  = 1'b0;
    bus.op_a      = 64'd0;
    bus.op_b      = 64'd0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_value("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check_value("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check_value("rst_result", bus.result, 128'd0);
    check_value("rst_busy", 128'(bus.busy), 128'd0);

    // 3 * 5 with the consumer always ready
    bus.out_ready = 1'b1;
    start_op(64'd3, 64'd5);
    check_value("busy_in_mul", 128'(bus.busy), 128'd1);
    wait_result(lat);
    check_value("lat_3x5", 128'(lat), 128'(LAT));
    check_value("res_3x5", bus.result, 128'd15);
    check_value("in_ready_done", 128'(bus.in_ready), 128'd0);
    @(negedge clk_i);
    check_value("in_ready_after_done", 128'(bus.in_ready), 128'd1);
    check_value("out_valid_after_done", 128'(bus.out_valid), 128'd0);
    check_value("result_held_idle", bus.result, 128'd15);

    // All-ones operands exercise every carry path
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_result(lat);
    check_value("lat_max", 128'(lat), 128'(LAT));
    check_value("res_max", bus.result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    @(negedge clk_i);

    // Backpressure in DONE, with an in_valid pulse that must be ignored
    bus.out_ready = 1'b0;
    start_op(64'h0002_0000_0000_0003, 64'h0000_0005_0000_0007);
    wait_result(lat);
    for (int c = 0; c < 6; c++) begin
      check_value("bp_out_valid", 128'(bus.out_valid), 128'd1);
      check_value("bp_result", bus.result, 128'h0000_0000_000A_0000_000E_000F_0000_0015);
      check_value("bp_in_ready", 128'(bus.in_ready), 128'd0);
      if (c == 1) begin
        bus.in_valid = 1'b1;
        bus.op_a     = 64'd11;
        bus.op_b     = 64'd13;
      end else if (c == 2) begin
        bus.in_valid = 1'b0;
      end else if (c == 5) begin
        bus.out_ready = 1'b1;
      end
      @(negedge clk_i);
    end
    check_value("bp_in_ready_after", 128'(bus.in_ready), 128'd1);
    check_value("bp_result_held", bus.result, 128'h0000_0000_000A_0000_000E_000F_0000_0015);
    seen = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (bus.busy || bus.out_valid) seen++;
    end
    check_value("bp_pulse_not_captured", 128'(seen), 128'd0);

    // Reset during the 8th MUL cycle of 2^63 * 2^63
    start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    repeat (7) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_value("abort_in_ready", 128'(bus.in_ready), 128'd1);
    check_value("abort_out_valid", 128'(bus.out_valid), 128'd0);
    check_value("abort_busy", 128'(bus.busy), 128'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk_i);
      if (bus.out_valid) seen++;
    end
    check_value("abort_no_emit", 128'(seen), 128'd0);
    start_op(64'd7, 64'd9);
    wait_result(lat);
    check_value("lat_7x9", 128'(lat), 128'(LAT));
    check_value("res_7x9", bus.result, 128'd63);
    @(negedge clk_i);

    // Back-to-back with in_valid held high: directed corners then random pairs
    va[0] = 64'd0;                   vb[0] = 64'hDEAD_BEEF_0123_4567;
    va[1] = 64'd1;                   vb[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    va[2] = 64'h0000_0001_0000_0001; vb[2] = 64'h0000_0001_0000_0001;
    va[3] = 64'hFFFF_0000_FFFF_0000; vb[3] = 64'h0000_FFFF_0000_FFFF;
    for (int n = 4; n < NOPS; n++) begin
      va[n] = {$urandom(), $urandom()};
      vb[n] = {$urandom(), $urandom()};
    end
    prev_cyc     = 0;
    bus.in_valid = 1'b1;
    bus.op_a     = va[0];
    bus.op_b     = vb[0];
    for (int n = 0; n < NOPS; n++) begin
      int k;
      k = 0;
      while (!bus.in_ready && k < 100) begin
        @(negedge clk_i);
        k++;
      end
      if (!bus.in_ready) check_value("b2b_accept_timeout", 128'd0, 128'd1);
      @(posedge clk_i);
      #1;
      if (n > 0) check_value("b2b_interval", 128'(cyc - prev_cyc), 128'(LAT + 1));
      prev_cyc = cyc;
      exp = {64'd0, va[n]} * {64'd0, vb[n]};
      if (n + 1 < NOPS) begin
        bus.op_a = va[n+1];
        bus.op_b = vb[n+1];
      end else begin
        bus.in_valid = 1'b0;
      end
      wait_result(lat);
      check_value("b2b_result", bus.result, exp);
    end
    bus.in_valid = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_value("b2b_idle_end", 128'(bus.busy), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
